// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC3 data-memory access sequencing logic.
package lc3_mem_pkg;

    // Phase codes driven to the memaccess stage; the encoding is the wire code.
    typedef enum logic [1:0] {
        MS_RD   = 2'b00,
        MS_IND  = 2'b01,
        MS_WR   = 2'b10,
        MS_IDLE = 2'b11
    } mem_state_t;

    // Opcodes (IR[15:12]) of the instructions that touch data memory.
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    // True for any opcode that needs a data-memory access.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_ST)  || (op == OP_STR) || (op == OP_STI);
    endfunction

    // First access phase for a memory opcode; indirect forms fetch the pointer first.
    function automatic mem_state_t first_phase(input logic [3:0] op);
        mem_state_t ph;
        case (op)
            OP_LD, OP_LDR:  ph = MS_RD;
            OP_ST, OP_STR:  ph = MS_WR;
            OP_LDI, OP_STI: ph = MS_IND;
            default:        ph = MS_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/mem_phase_timer.sv
// Saturating phase counter: measures how long the controller has sat in the
// current access phase and flags when the minimum phase length is reached.
module mem_phase_timer #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic phase_last
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over counting; counting stops at LAST so a stalled memory keeps it there.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign phase_last = (count_q == LAST);

endmodule

// File: rtl/lc3_mem_state_ctrl.sv
// LC3 control-unit sequencer for data-memory instructions: walks LD/LDR/LDI/
// ST/STR/STI through their read, write and indirect-pointer phases and holds
// the pipeline while an access is in flight.
module lc3_mem_state_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] IR_op,
    input  logic       dmem_ready,
    output logic [1:0] mem_state,
    output logic       mem_busy,
    output logic       stall_pipe,
    output logic       ind_capture,
    output logic       mem_done,
    output logic       illegal_op
);

    mem_state_t state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic       accept;
    logic       phase_done;
    logic       phase_last;
    logic       timer_clear;
    logic       timer_enable;

    mem_phase_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .enable     (timer_enable),
        .phase_last (phase_last)
    );

    // Next-state logic: accept new work only in IDLE, advance a phase once its
    // minimum length has elapsed and memory reports ready.
    always_comb begin
        accept       = (state_q == MS_IDLE) && start && is_mem_op(IR_op);
        phase_done   = (state_q != MS_IDLE) && phase_last && dmem_ready;
        state_d      = state_q;
        op_d         = op_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (start) begin
                    if (is_mem_op(IR_op)) begin
                        state_d = first_phase(IR_op);
                        op_d    = IR_op;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            MS_IND: begin
                if (phase_done) begin
                    state_d = (op_q == OP_LDI) ? MS_RD : MS_WR;
                end
            end
            MS_RD, MS_WR: begin
                if (phase_done) begin
                    state_d = MS_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
        busy_d       = (state_d != MS_IDLE);
        timer_clear  = accept || phase_done;
        timer_enable = (state_q != MS_IDLE);
    end

    // FSM state, latched opcode and registered handshakes; reset drops any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= MS_IDLE;
            op_q      <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_state   = state_q;
    assign mem_busy    = busy_q;
    assign mem_done    = done_q;
    assign illegal_op  = illegal_q;
    assign ind_capture = !reset && (state_q == MS_IND) && phase_done;
    assign stall_pipe  = !reset && (busy_q || accept);

endmodule

// File: tb/tb_lc3_mem_state_ctrl.sv
// Directed bench for the LC3 memory-phase sequencer: one instance with
// single-cycle phases and one with three-cycle phases share the stimulus.
module tb_lc3_mem_state_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] IR_op;
    logic       dmem_ready;

    logic [1:0] ms1, ms3;
    logic       busy1, busy3, stall1, stall3, ind1, ind3, done1, done3, ill1, ill3;

    int vectors     = 0;
    int miscompares = 0;

    lc3_mem_state_ctrl #(.ACCESS_CYCLES(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .IR_op       (IR_op),
        .dmem_ready  (dmem_ready),
        .mem_state   (ms1),
        .mem_busy    (busy1),
        .stall_pipe  (stall1),
        .ind_capture (ind1),
        .mem_done    (done1),
        .illegal_op  (ill1)
    );

    lc3_mem_state_ctrl #(.ACCESS_CYCLES(3)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .IR_op       (IR_op),
        .dmem_ready  (dmem_ready),
        .mem_state   (ms3),
        .mem_busy    (busy3),
        .stall_pipe  (stall3),
        .ind_capture (ind3),
        .mem_done    (done3),
        .illegal_op  (ill3)
    );

    always #5 clock = ~clock;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task tick;
        @(posedge clock);
        #1;
    endtask

    task applyStimulus(input logic r, input logic s, input logic [3:0] op, input logic rdy);
        reset      = r;
        start      = s;
        IR_op      = op;
        dmem_ready = rdy;
        #1;
    endtask

    task cmp(input string name, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0b expected %0b", name, obs, exp);
        end
    endtask

    task checkOutput(input string tag, input bit use3, input logic [1:0] e_ms,
                     input logic e_busy, input logic e_stall, input logic e_ind,
                     input logic e_done, input logic e_ill);
        cmp({tag, ".mem_state"},   use3 ? ms3    : ms1,    e_ms);
        cmp({tag, ".mem_busy"},    use3 ? busy3  : busy1,  {1'b0, e_busy});
        cmp({tag, ".stall_pipe"},  use3 ? stall3 : stall1, {1'b0, e_stall});
        cmp({tag, ".ind_capture"}, use3 ? ind3   : ind1,   {1'b0, e_ind});
        cmp({tag, ".mem_done"},    use3 ? done3  : done1,  {1'b0, e_done});
        cmp({tag, ".illegal_op"},  use3 ? ill3   : ill1,   {1'b0, e_ill});
    endtask

    initial begin
        // Reset held with a legal start: reset must win and stall stays low.
        applyStimulus(1, 1, 4'b0010, 1);
        tick;
        tick;
        checkOutput("rst_hold", 0, 2'b11, 0, 0, 0, 0, 0);
        tick;
        checkOutput("rst_start", 0, 2'b11, 0, 0, 0, 0, 0);

        // LD: 11 (start), 00, 11 with done.
        applyStimulus(0, 1, 4'b0010, 1);
        checkOutput("ld_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0010, 1);
        checkOutput("ld_c1", 0, 2'b00, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("ld_c2", 0, 2'b11, 0, 0, 0, 1, 0);
        tick;
        checkOutput("ld_c3", 0, 2'b11, 0, 0, 0, 0, 0);

        // STI: 01 with ind_capture, 10, 11 with done.
        applyStimulus(0, 1, 4'b1011, 1);
        checkOutput("sti_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b1011, 1);
        checkOutput("sti_c1", 0, 2'b01, 1, 1, 1, 0, 0);
        tick;
        checkOutput("sti_c2", 0, 2'b10, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("sti_c3", 0, 2'b11, 0, 0, 0, 1, 0);
        tick;

        // LDR with memory not ready for four cycles.
        applyStimulus(0, 1, 4'b0110, 0);
        checkOutput("ldr_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 4'b0110, 0);
            checkOutput($sformatf("ldr_wait%0d", i), 0, 2'b00, 1, 1, 0, 0, 0);
            tick;
        end
        applyStimulus(0, 0, 4'b0110, 1);
        checkOutput("ldr_c5", 0, 2'b00, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("ldr_c6", 0, 2'b11, 0, 0, 0, 1, 0);
        tick;

        // Illegal opcode (ADD) from IDLE.
        applyStimulus(0, 1, 4'b0001, 1);
        checkOutput("ill_c0", 0, 2'b11, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0001, 1);
        checkOutput("ill_c1", 0, 2'b11, 0, 0, 0, 0, 1);
        tick;
        checkOutput("ill_c2", 0, 2'b11, 0, 0, 0, 0, 0);

        // LDI with a stalled pointer read, opcode change while busy, then reset in RD.
        applyStimulus(0, 1, 4'b1010, 0);
        checkOutput("ldi_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 1, 4'b1011, 0);
        checkOutput("ldi_c1", 0, 2'b01, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b1011, 1);
        checkOutput("ldi_c2", 0, 2'b01, 1, 1, 1, 0, 0);
        tick;
        applyStimulus(1, 0, 4'b1011, 1);
        checkOutput("ldi_c3", 0, 2'b00, 1, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("ldi_rst", 0, 2'b11, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 1, 4'b0011, 1);
        checkOutput("st_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0011, 1);
        checkOutput("st_c1", 0, 2'b10, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("st_c2", 0, 2'b11, 0, 0, 0, 1, 0);
        tick;

        // Back-to-back ST then LD, with a start ignored while busy.
        applyStimulus(0, 1, 4'b0011, 1);
        checkOutput("b2b_c0", 0, 2'b11, 0, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 1, 4'b1010, 1);
        checkOutput("b2b_c1", 0, 2'b10, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 1, 4'b0010, 1);
        checkOutput("b2b_c2", 0, 2'b11, 0, 1, 0, 1, 0);
        tick;
        applyStimulus(0, 0, 4'b1011, 1);
        checkOutput("b2b_c3", 0, 2'b00, 1, 1, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("b2b_c4", 0, 2'b11, 0, 0, 0, 1, 0);
        tick;
        checkOutput("b2b_c5", 0, 2'b11, 0, 0, 0, 0, 0);

        // Three-cycle phase instance: LDR holds 00 for three cycles.
        applyStimulus(1, 0, 4'b0000, 1);
        tick;
        applyStimulus(0, 1, 4'b0110, 1);
        checkOutput("ac3_c0", 1, 2'b11, 0, 1, 0, 0, 0);
        tick;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 4'b0110, 1);
            checkOutput($sformatf("ac3_c%0d", i), 1, 2'b00, 1, 1, 0, 0, 0);
            tick;
        end
        applyStimulus(0, 0, 4'b0000, 1);
        checkOutput("ac3_c4", 1, 2'b11, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
